abr_sha3_digest_reader: RTL and testbench

Streams the Keccak digest out of the SHA3 core as 64-bit words over a valid/ready interface. It sits directly downstream of the SHA3 core and consumes its `state_o` / `state_valid_o` outputs. It drives the core's `state_valid_hold_i` and `run_i` so SHAKE/cSHAKE outputs longer than one rate block are squeezed automatically, with no software involvement.

---
 rtl/abr_sha3_digest_reader.sv | 168 ++++++++++++++++
 tb/tb_abr_sha3_digest_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/abr_sha3_digest_reader.sv
// Streams the SHA3 Keccak digest as OutW-bit words over valid/ready, squeezing extra blocks itself.
// Optional feature macro: ABR_SHA3_DIGEST_MASKED_EN (two independent shares on state_i/data_o).
module abr_sha3_digest_reader #(
  parameter int unsigned StateW = 1600,
  parameter int unsigned OutW   = 64,
  parameter int unsigned LenW   = 16,
`ifdef ABR_SHA3_DIGEST_MASKED_EN
  localparam int unsigned Share = 2
`else
  localparam int unsigned Share = 1
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_b,
  input  logic                    zeroize,
  input  logic                    start_i,
  input  logic [LenW-1:0]         out_len_i,
  input  logic [4:0]              rate_words_i,
  input  logic                    state_valid_i,
  input  logic [StateW*Share-1:0] state_i,
  output logic                    state_hold_o,
  output logic                    run_o,
  output logic [OutW*Share-1:0]   data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    done_o,
  output logic                    busy_o,
  output logic                    error_o
);

  localparam int unsigned IdxW = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_STATE = 3'd1,
    ST_STREAM     = 3'd2,
    ST_WAIT_RUN   = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       rate_q, rate_d;
  logic [LenW-1:0]       rem_q, rem_d;
  logic                  seen_low_q, seen_low_d;
  logic                  run_d, err_d;
  logic [OutW*Share-1:0] data_d;

  function automatic logic rate_legal(input logic [4:0] r);
    return (r == 5'd9) || (r == 5'd13) || (r == 5'd17) || (r == 5'd18) || (r == 5'd21);
  endfunction

  // Next-state and control decode
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rate_d     = rate_q;
    rem_d      = rem_q;
    seen_low_d = seen_low_q;
    run_d      = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (out_len_i == '0) begin
            state_d = ST_DONE;
          end else if (!rate_legal(rate_words_i)) begin
            err_d = 1'b1;
          end else begin
            rem_d   = out_len_i;
            rate_d  = rate_words_i;
            idx_d   = '0;
            state_d = ST_WAIT_STATE;
          end
        end
      end
      ST_WAIT_STATE: begin
        if (state_valid_i) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (ready_i) begin
          rem_d = rem_q - LenW'(1);
          if (rem_q == LenW'(1)) begin
            state_d = ST_DONE;
          end else if (idx_q == rate_q - IdxW'(1)) begin
            idx_d      = '0;
            run_d      = 1'b1;
            seen_low_d = 1'b0;
            state_d    = ST_WAIT_RUN;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      ST_WAIT_RUN: begin
        // The core must visibly drop state_valid before the next block counts as fresh.
        if (!state_valid_i) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          state_d = ST_STREAM;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    endcase
    if (start_i && (state_q != ST_IDLE)) err_d = 1'b1;
  end

  // Per-share word slice; each share is extracted on its own and zero outside Stream
  always_comb begin
    data_d = '0;
    if (state_d == ST_STREAM) begin
      for (int unsigned s = 0; s < Share; s++) begin
        data_d[s*OutW +: OutW] = state_i[s*StateW + OutW*32'(idx_d) +: OutW];
      end
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      rate_q       <= '0;
      rem_q        <= '0;
      seen_low_q   <= 1'b0;
      state_hold_o <= 1'b0;
      run_o        <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
    end else if (zeroize) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      rate_q       <= '0;
      rem_q        <= '0;
      seen_low_q   <= 1'b0;
      state_hold_o <= 1'b0;
      run_o        <= 1'b0;
      data_o       <= '0;
      valid_o      <= 1'b0;
      done_o       <= 1'b0;
      busy_o       <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rate_q       <= rate_d;
      rem_q        <= rem_d;
      seen_low_q   <= seen_low_d;
      state_hold_o <= (state_d == ST_WAIT_STATE) || (state_d == ST_STREAM);
      run_o        <= run_d;
      data_o       <= data_d;
      valid_o      <= (state_d == ST_STREAM);
      done_o       <= (state_d == ST_DONE);
      busy_o       <= (state_d != ST_IDLE);
      error_o      <= err_d;
    end
  end

endmodule

// File: tb/tb_abr_sha3_digest_reader.sv
// Self-checking bench for abr_sha3_digest_reader: a queue-based digest model plus a simple SHA3 core model.
module tb_abr_sha3_digest_reader;

`ifdef ABR_SHA3_DIGEST_MASKED_EN
  localparam int Share = 2;
`else
  localparam int Share = 1;
`endif
  localparam int StateW = 1600;
  localparam int OutW   = 64;
  localparam int LenW   = 16;
  localparam int Budget = 3000;

  typedef logic [StateW*Share-1:0] blk_t;

  logic                  clk_i = 1'b0;
  logic                  rst_b = 1'b0;
  logic                  zeroize = 1'b0;
  logic                  start_i = 1'b0;
  logic [LenW-1:0]       out_len_i = '0;
  logic [4:0]            rate_words_i = '0;
  logic                  state_valid_i = 1'b0;
  blk_t                  state_i = '0;
  logic                  state_hold_o;
  logic                  run_o;
  logic [OutW*Share-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i = 1'b0;
  logic                  done_o;
  logic                  busy_o;
  logic                  error_o;

  int n_assert = 0;
  int n_fail   = 0;

  abr_sha3_digest_reader dut (
    .clk_i         (clk_i),
    .rst_b         (rst_b),
    .zeroize       (zeroize),
    .start_i       (start_i),
    .out_len_i     (out_len_i),
    .rate_words_i  (rate_words_i),
    .state_valid_i (state_valid_i),
    .state_i       (state_i),
    .state_hold_o  (state_hold_o),
    .run_o         (run_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .error_o       (error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic blk_t rand_block();
    blk_t v;
    for (int i = 0; i < StateW*Share/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Expected word k of the squeezed output: block k/rate, lane k%rate, each share on its own
  function automatic logic [127:0] exp_word(input blk_t b, input int lane);
    logic [127:0] w;
    w = '0;
    for (int s = 0; s < Share; s++) w[s*OutW +: OutW] = b[s*StateW + OutW*lane +: OutW];
    return w;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hold"},  128'(state_hold_o), 128'(0));
    chk({tag, "_run"},   128'(run_o),        128'(0));
    chk({tag, "_data"},  128'(data_o),       128'(0));
    chk({tag, "_valid"}, 128'(valid_o),      128'(0));
    chk({tag, "_done"},  128'(done_o),       128'(0));
    chk({tag, "_busy"},  128'(busy_o),       128'(0));
    chk({tag, "_error"}, 128'(error_o),      128'(0));
  endtask

  // mode: 0 ready tied 1, 1 random, 2 pattern 1,0,0,1. dropn: 0 random gap, else fixed gap.
  task automatic run_stream(input int len, input int rate, input int mode, input int dropn,
                            input int err_at, input int zero_at);
    blk_t blocks[$];
    int nblk, got, nb, runs, drop, k;
    bit hs, hs_prev, stalled, exp_vnext, err_next, err_now, err_done, finished;
    bit exp_run, exp_done;
    logic [127:0] stall_data;
    int pat[4] = '{1, 0, 0, 1};

    nblk = (len + rate - 1) / rate;
    for (int i = 0; i < nblk; i++) blocks.push_back(rand_block());
    got = 0; nb = 0; runs = 0; k = 0;
    hs_prev = 0; stalled = 0; exp_vnext = 0; err_next = 0; err_done = 0; finished = 0;
    stall_data = '0;

    start_i = 1'b1; out_len_i = LenW'(len); rate_words_i = 5'(rate);
    state_valid_i = 1'b0; ready_i = 1'b0;
    step();
    start_i = 1'b0;
    chk("busy_after_start", 128'(busy_o), 128'(1));
    drop = (dropn == 0) ? $urandom_range(1, 3) : dropn;

    for (int cyc = 0; cyc < Budget && !finished; cyc++) begin
      err_now = err_next; err_next = 0;
      start_i = 1'b0;
      if (exp_vnext) chk("valid_after_state_valid", 128'(valid_o), 128'(1));
      exp_vnext = 0;
      if (!valid_o) chk("data_zero_when_invalid", 128'(data_o), 128'(0));
      else chk("hold_in_stream", 128'(state_hold_o), 128'(1));
      if (stalled) begin
        chk("stall_valid_held", 128'(valid_o), 128'(1));
        chk("stall_data_stable", 128'(data_o), stall_data);
      end
      chk("error_o", 128'(error_o), 128'(err_now));

      exp_run  = hs_prev && (got % rate == 0) && (got < len);
      exp_done = hs_prev && (got == len);
      chk("run_o", 128'(run_o), 128'(exp_run));
      chk("done_o", 128'(done_o), 128'(exp_done));

      if (exp_done) begin
        ready_i = 1'b0; state_valid_i = 1'b0;
        step();
        chk("busy_clear_after_done", 128'(busy_o), 128'(0));
        chk("done_single_pulse", 128'(done_o), 128'(0));
        chk("valid_low_after_done", 128'(valid_o), 128'(0));
        chk("run_count", 128'(runs), 128'(nblk - 1));
        finished = 1;
      end else if (zero_at >= 0 && got == zero_at) begin
        zeroize = 1'b1; ready_i = 1'b0;
        step();
        zeroize = 1'b0; state_valid_i = 1'b0;
        chk_all_zero("zeroize");
        finished = 1;
      end else begin
        // Core model: drop state_valid after a run pulse, re-raise with the next block
        if (exp_run) begin
          runs++;
          chk("hold_low_on_run", 128'(state_hold_o), 128'(0));
          state_valid_i = 1'b0;
          drop = (dropn == 0) ? $urandom_range(1, 3) : dropn;
        end else if (drop > 0) begin
          drop--;
          if (drop == 0) begin
            state_i = blocks[nb]; nb++;
            state_valid_i = 1'b1;
            exp_vnext = 1;
          end
        end
        if (err_at >= 0 && got == err_at && !err_done && valid_o) begin
          start_i = 1'b1; out_len_i = LenW'(3); rate_words_i = 5'd9;
          err_next = 1; err_done = 1;
        end
        case (mode)
          0:       ready_i = 1'b1;
          1:       ready_i = 1'($urandom_range(0, 1));
          default: ready_i = 1'(pat[k % 4]);
        endcase
        if (valid_o) k++;
        hs = valid_o && ready_i;
        if (hs) begin
          chk("word", 128'(data_o), exp_word(blocks[got / rate], got % rate));
          got++;
        end
        stalled = valid_o && !ready_i;
        stall_data = 128'(data_o);
        hs_prev = hs;
        step();
      end
    end
    if (!finished) chk("stream_timeout", 128'(0), 128'(1));
    start_i = 1'b0; ready_i = 1'b0; state_valid_i = 1'b0;
  endtask

  initial begin
    int rates[5] = '{9, 13, 17, 18, 21};

    rst_b = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst_b = 1'b1;
    step();
    chk_all_zero("idle_after_reset");

    run_stream(4, 17, 0, 2, -1, -1);
    run_stream(25, 21, 0, 2, -1, -1);
    run_stream(12, 9, 2, 1, -1, -1);

    start_i = 1'b1; out_len_i = '0; rate_words_i = 5'd17;
    step();
    start_i = 1'b0;
    chk("len0_done", 128'(done_o), 128'(1));
    chk("len0_valid", 128'(valid_o), 128'(0));
    chk("len0_busy", 128'(busy_o), 128'(1));
    step();
    chk("len0_done_end", 128'(done_o), 128'(0));
    chk("len0_busy_end", 128'(busy_o), 128'(0));
    chk("len0_valid_end", 128'(valid_o), 128'(0));

    start_i = 1'b1; out_len_i = LenW'(5); rate_words_i = 5'd10;
    step();
    start_i = 1'b0;
    chk("badrate_error", 128'(error_o), 128'(1));
    chk("badrate_busy", 128'(busy_o), 128'(0));
    step();
    chk("badrate_error_end", 128'(error_o), 128'(0));
    chk("badrate_busy_end", 128'(busy_o), 128'(0));

    run_stream(20, 13, 0, 1, 3, -1);
    run_stream(10, 17, 0, 1, -1, 5);
    run_stream(6, 18, 1, 0, -1, -1);

    for (int i = 0; i < 8; i++) begin
      run_stream($urandom_range(1, 50), rates[$urandom_range(0, 4)], 1, 0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
